// File: rtl/cdc_word_sender.sv
// Master-domain sender for cdc_handshake: buffers stream words in a FIFO and
// sends them one at a time as a request pulse plus a held data word.
module cdc_word_sender #(
    parameter int DATA_W         = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [DATA_W-1:0]             s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic                          hs_req_o,
    input  logic                          hs_ack_i,
    output logic [DATA_W-1:0]             hs_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          busy_o,
    output logic                          timeout_o,
    input  logic                          timeout_clr_i
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FW  = AW + 1;
    localparam int TCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TCW-1:0] TO_LIM = TCW'(TIMEOUT_CYCLES);
    localparam logic [FW-1:0]  FULL_N = FW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [FW-1:0]     fill_q, fill_d;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              req_q;
    logic [TCW-1:0]    tcnt_q, tcnt_d;
    logic              tout_q, tout_d;
    logic              push, pop, full, to_set;

    assign full      = (fill_q == FULL_N);
    assign push      = s_valid_i && !full;
    assign pop       = (state_q == IDLE) && (fill_q != '0);
    assign s_ready_o = !full;
    assign hs_req_o  = req_q;
    assign hs_data_o = data_q;
    assign fill_o    = fill_q;
    assign busy_o    = (state_q != IDLE);
    assign timeout_o = tout_q;

    // FIFO storage; contents are don't-care until the pointers cover them
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q] <= s_data_i;
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fill_d = fill_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        if (push && !pop) fill_d = fill_q + 1'b1;
        if (pop && !push) fill_d = fill_q - 1'b1;
    end

    // FSM next-state, holding register load and ack-wait timer
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tcnt_d  = tcnt_q;
        to_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    data_d  = mem[rptr_q];
                    tcnt_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = hs_ack_i ? IDLE : WAIT;
            end
            WAIT: begin
                if (tcnt_q != TO_LIM) tcnt_d = tcnt_q + 1'b1;
                to_set = (TIMEOUT_CYCLES != 0) && (tcnt_q != TO_LIM) &&
                         (tcnt_d == TO_LIM);
                if (hs_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        tout_d = to_set ? 1'b1 : (timeout_clr_i ? 1'b0 : tout_q);
    end

    // State registers; the request is a registered copy of the REQ state,
    // so it is glitch-free and lasts exactly one cycle per word
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            tcnt_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= (state_q == REQ);
            tcnt_q  <= tcnt_d;
            tout_q  <= tout_d;
        end
    end

endmodule

// File: tb/tb_cdc_word_sender.sv
// Directed self-checking bench for cdc_word_sender (DEPTH=4, TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cdc_word_sender;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] s_data_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic        hs_req_o;
    logic        hs_ack_i;
    logic [31:0] hs_data_o;
    logic [2:0]  fill_o;
    logic        busy_o;
    logic        timeout_o;
    logic        timeout_clr_i;

    int errors = 0;
    int checks = 0;
    int req_cnt = 0;
    bit prev_req = 0;
    bit dbl_req = 0;

    always #5 clk_i = ~clk_i;

    cdc_word_sender #(
        .DATA_W(32),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .s_data_i(s_data_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .hs_req_o(hs_req_o),
        .hs_ack_i(hs_ack_i),
        .hs_data_o(hs_data_o),
        .fill_o(fill_o),
        .busy_o(busy_o),
        .timeout_o(timeout_o),
        .timeout_clr_i(timeout_clr_i)
    );

    // Request pulse monitor, sampled just after each rising edge
    always @(posedge clk_i) begin
        #1;
        if (hs_req_o) req_cnt++;
        if (hs_req_o && prev_req) dbl_req = 1;
        prev_req = hs_req_o;
    end

    task automatic push_word(input logic [31:0] w, output bit ok);
        bit rdy;
        int n;
        n = 0;
        s_data_i = w;
        s_valid_i = 1'b1;
        do begin
            rdy = s_ready_o;
            @(negedge clk_i);
            n++;
        end while (!rdy && n < 50);
        s_valid_i = 1'b0;
        ok = rdy;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_i);
            if (hs_req_o) ok = 1;
        end
    endtask

    task automatic ack_pulse();
        hs_ack_i = 1'b1;
        @(negedge clk_i);
        hs_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (s_ready_o !== 1'b1 || fill_o !== 3'd0 || hs_req_o !== 1'b0 ||
            busy_o !== 1'b0 || hs_data_o !== 32'h0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b fill=%0d req=%b busy=%b data=%h to=%b",
                     s_ready_o, fill_o, hs_req_o, busy_o, hs_data_o, timeout_o);
        end
        rst_n_i = 1'b1;
        base = req_cnt;
        repeat (10) @(negedge clk_i);
        checks++;
        if (req_cnt !== base || fill_o !== 3'd0 || s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: reqs=%0d fill=%0d rdy=%b, want 0/0/1",
                     req_cnt - base, fill_o, s_ready_o);
        end
    endtask

    task automatic test_single_word(input logic [31:0] w);
        int base;
        base = req_cnt;
        s_data_i = w;
        s_valid_i = 1'b1;
        @(negedge clk_i);
        s_valid_i = 1'b0;
        checks++;
        if (fill_o !== 3'd1 || hs_req_o !== 1'b0) begin
            errors++;
            $display("FAIL single_push: fill=%0d req=%b, want 1/0", fill_o, hs_req_o);
        end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1 || hs_data_o !== w || hs_req_o !== 1'b0 || fill_o !== 3'd0) begin
            errors++;
            $display("FAIL single_pop: busy=%b data=%h req=%b fill=%0d, want 1/%h/0/0",
                     busy_o, hs_data_o, hs_req_o, fill_o, w);
        end
        @(negedge clk_i);
        checks++;
        if (hs_req_o !== 1'b1) begin
            errors++;
            $display("FAIL single_req_latency: req=%b, want 1", hs_req_o);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++;
            if (hs_req_o !== 1'b0 || hs_data_o !== w || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL single_hold[%0d]: req=%b data=%h busy=%b, want 0/%h/1",
                         i, hs_req_o, hs_data_o, busy_o, w);
            end
        end
        ack_pulse();
        checks++;
        if (busy_o !== 1'b0 || hs_data_o !== w || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: busy=%b data=%h to=%b, want 0/%h/0",
                     busy_o, hs_data_o, timeout_o, w);
        end
        repeat (3) @(negedge clk_i);
        checks++;
        if (req_cnt - base !== 1) begin
            errors++;
            $display("FAIL single_req_count: got %0d, want 1", req_cnt - base);
        end
    endtask

    task automatic test_burst();
        logic [31:0] exp [6];
        bit ok;
        bit ok5;
        int base;
        base = req_cnt;
        for (int i = 0; i < 6; i++) exp[i] = 32'h1000_0000 + 32'(i * 17);
        for (int i = 0; i < 5; i++) begin
            push_word(exp[i], ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL burst_push[%0d]: not accepted, want accepted", i);
            end
        end
        checks++;
        if (fill_o !== 3'd4 || s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL burst_full: fill=%0d rdy=%b, want 4/0", fill_o, s_ready_o);
        end
        fork
            push_word(exp[5], ok5);
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i > 0) begin
                        wait_req(ok);
                        checks++;
                        if (!ok) begin
                            errors++;
                            $display("FAIL burst_req[%0d]: no request, want request", i);
                        end
                    end
                    checks++;
                    if (hs_data_o !== exp[i]) begin
                        errors++;
                        $display("FAIL burst_order[%0d]: data=%h, want %h",
                                 i, hs_data_o, exp[i]);
                    end
                    repeat (2) @(negedge clk_i);
                    ack_pulse();
                end
            end
        join
        checks++;
        if (!ok5) begin
            errors++;
            $display("FAIL burst_push[5]: not accepted, want accepted");
        end
        repeat (5) @(negedge clk_i);
        checks++;
        if (req_cnt - base !== 6 || fill_o !== 3'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: reqs=%0d fill=%0d busy=%b, want 6/0/0",
                     req_cnt - base, fill_o, busy_o);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int base;
        base = req_cnt;
        push_word(32'hDEAD_0016, ok);
        wait_req(ok);
        checks++;
        if (!ok || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL to_start: req_seen=%b to=%b, want 1/0", ok, timeout_o);
        end
        repeat (15) @(negedge clk_i);
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL to_early: to=%b after 15 wait cycles, want 0", timeout_o);
        end
        @(negedge clk_i);
        checks++;
        if (timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL to_set: to=%b after 16 wait cycles, want 1", timeout_o);
        end
        repeat (20) @(negedge clk_i);
        checks++;
        if (req_cnt - base !== 1 || busy_o !== 1'b1 || timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL to_no_retry: reqs=%0d busy=%b to=%b, want 1/1/1",
                     req_cnt - base, busy_o, timeout_o);
        end
        ack_pulse();
        checks++;
        if (busy_o !== 1'b0 || timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL to_late_ack: busy=%b to=%b, want 0/1", busy_o, timeout_o);
        end
        timeout_clr_i = 1'b1;
        @(negedge clk_i);
        timeout_clr_i = 1'b0;
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: to=%b, want 0", timeout_o);
        end
    endtask

    task automatic test_stray_ack();
        int base;
        base = req_cnt;
        ack_pulse();
        repeat (3) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || fill_o !== 3'd0 || timeout_o !== 1'b0 ||
            req_cnt !== base) begin
            errors++;
            $display("FAIL stray_ack: busy=%b fill=%0d to=%b reqs=%0d, want 0/0/0/0",
                     busy_o, fill_o, timeout_o, req_cnt - base);
        end
        test_single_word(32'h5A5A_0005);
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int base;
        push_word(32'hC0DE_0000, ok);
        wait_req(ok);
        for (int i = 1; i < 4; i++) push_word(32'hC0DE_0000 + 32'(i), ok);
        checks++;
        if (fill_o !== 3'd3 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rstw_setup: fill=%0d busy=%b, want 3/1", fill_o, busy_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (fill_o !== 3'd0 || busy_o !== 1'b0 || s_ready_o !== 1'b1 ||
            hs_data_o !== 32'h0 || hs_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rstw_async: fill=%0d busy=%b rdy=%b data=%h req=%b",
                     fill_o, busy_o, s_ready_o, hs_data_o, hs_req_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        base = req_cnt;
        repeat (20) @(negedge clk_i);
        checks++;
        if (req_cnt !== base || fill_o !== 3'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstw_release: reqs=%0d fill=%0d busy=%b, want 0/0/0",
                     req_cnt - base, fill_o, busy_o);
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        s_data_i = '0;
        s_valid_i = 1'b0;
        hs_ack_i = 1'b0;
        timeout_clr_i = 1'b0;
        test_reset();
        test_single_word(32'hA5A5_0001);
        test_burst();
        test_timeout();
        test_stray_ack();
        test_reset_mid_wait();
        checks++;
        if (dbl_req !== 1'b0) begin
            errors++;
            $display("FAIL req_pulse_width: two-cycle request seen=%b, want 0", dbl_req);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
